// File: rtl/instruction_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder_pkg
// Description : Shared encodings for the 4-bit lab microprocessor decoder:
//               opcode prefixes, destination/source register codes, the
//               instruction class enum and the NOP / reset instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_decoder_pkg;

  // Opcode prefixes, matched against the leading bits of the IR
  localparam logic       OP_LOAD = 1'b0;      // 0ddd nnnn
  localparam logic [1:0] OP_MOV  = 2'b10;     // 10dd dsss
  localparam logic [2:0] OP_ALU  = 3'b110;    // 110x yfff
  localparam logic [3:0] OP_JMP  = 4'b1110;   // 1110 aaaa
  localparam logic [3:0] OP_JNZ  = 4'b1111;   // 1111 aaaa

  // mov x0,x0 is the canonical NOP and the reset contents of the IR
  localparam logic [7:0] NOP_INSTR = 8'h80;

  localparam int ALU_FUNC_W = 3;

  // Destination encodings (one-hot index into reg_wr_en)
  typedef enum logic [2:0] {
    DST_X0 = 3'd0, DST_X1 = 3'd1, DST_Y0 = 3'd2, DST_Y1 = 3'd3,
    DST_O  = 3'd4, DST_M  = 3'd5, DST_I  = 3'd6, DST_DM = 3'd7
  } dst_e;

  // mov source encodings
  typedef enum logic [2:0] {
    SRC_X0 = 3'd0, SRC_X1 = 3'd1, SRC_Y0 = 3'd2, SRC_Y1 = 3'd3,
    SRC_R  = 3'd4, SRC_M  = 3'd5, SRC_I  = 3'd6, SRC_IPINS = 3'd7
  } src_e;

  typedef enum logic [2:0] {
    CLS_LOAD = 3'd0,
    CLS_MOV  = 3'd1,
    CLS_ALU  = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_JNZ  = 3'd4
  } instr_class_e;

  // Classify an instruction word by its prefix
  function automatic instr_class_e classify(input logic [7:0] instr);
    if (instr[7] == OP_LOAD)           return CLS_LOAD;
    else if (instr[7:6] == OP_MOV)     return CLS_MOV;
    else if (instr[7:5] == OP_ALU)     return CLS_ALU;
    else if (instr[7:4] == OP_JMP)     return CLS_JMP;
    else                               return CLS_JNZ;
  endfunction

endpackage : instruction_decoder_pkg
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decoder
// Description : Instruction register, zero flag and decode for the 4-bit lab
//               microprocessor. Captures pm_data on the sequencer run phase
//               and produces phase-3 write strobes / jump requests plus
//               continuously decoded operand selects.
// Ports       : clk, reset_n        - clock, async active-low reset
//               pm_data, run,       - program word, capture enable,
//               pc_count, alu_zero  - sequencer phase, ALU zero result
//               ir, dont_jmp        - instruction register, zero flag
//               jmp, jmp_nz,        - jump requests and target nibble
//               jmp_addr
//               reg_wr_en, r_wr_en  - destination / result write strobes
//               src_sel, src_is_imm,- mov source, load select, immediate
//               imm
//               alu_xsel, alu_ysel, - ALU operand selects and function
//               alu_func
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter logic [7:0] IR_RESET = NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            pm_data,
  input  logic                  run,
  input  logic [1:0]            pc_count,
  input  logic                  alu_zero,
  output logic [7:0]            ir,
  output logic                  jmp,
  output logic                  jmp_nz,
  output logic [3:0]            jmp_addr,
  output logic                  dont_jmp,
  output logic [7:0]            reg_wr_en,
  output logic                  r_wr_en,
  output logic [2:0]            src_sel,
  output logic                  src_is_imm,
  output logic [3:0]            imm,
  output logic                  alu_xsel,
  output logic                  alu_ysel,
  output logic [ALU_FUNC_W-1:0] alu_func
);

  logic [7:0]   r_ir;
  logic         r_dont_jmp;
  instr_class_e w_class;
  logic         w_exec;
  logic [2:0]   w_dst;
  logic [2:0]   w_src;
  logic         w_mov_nop;

  assign w_class = classify(r_ir);
  assign w_exec  = (pc_count == 2'd3);
  assign w_dst   = r_ir[5:3];
  assign w_src   = r_ir[2:0];
  // mov r->o_reg shares code 4 on both sides but is a real transfer
  assign w_mov_nop = (w_dst == w_src) && (w_dst != DST_O);

  // The flag update looks at the IR value before any capture on the same
  // edge, so a stray run in phase 3 cannot retarget the flag write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ir       <= IR_RESET;
      r_dont_jmp <= 1'b0;
    end else begin
      if (w_exec && (w_class == CLS_ALU))
        r_dont_jmp <= alu_zero;
      if (run)
        r_ir <= pm_data;
    end
  end

  // Strobes only in the execute phase; everything else is pure field decode.
  always_comb begin
    reg_wr_en = 8'h00;
    r_wr_en   = 1'b0;
    jmp       = 1'b0;
    jmp_nz    = 1'b0;
    if (w_exec) begin
      case (w_class)
        CLS_LOAD: reg_wr_en = 8'h01 << r_ir[6:4];
        CLS_MOV:  if (!w_mov_nop) reg_wr_en = 8'h01 << w_dst;
        CLS_ALU:  r_wr_en = 1'b1;
        CLS_JMP:  jmp     = 1'b1;
        CLS_JNZ:  jmp_nz  = 1'b1;
        default:  ;
      endcase
    end
  end

  assign ir         = r_ir;
  assign dont_jmp   = r_dont_jmp;
  assign jmp_addr   = r_ir[3:0];
  assign imm        = r_ir[3:0];
  assign src_sel    = w_src;
  assign src_is_imm = (w_class == CLS_LOAD);
  assign alu_xsel   = r_ir[4];
  assign alu_ysel   = r_ir[3];
  assign alu_func   = r_ir[2:0];

endmodule : instruction_decoder
`default_nettype wire

// File: tb/tb_instruction_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_decoder
// Description : Self-checking bench for instruction_decoder. Drives a 4-phase
//               sequencer, directed program plus random instruction slots, and
//               compares all outputs against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       run;
  logic [1:0] pc_count;
  logic       alu_zero;
  logic [7:0] ir;
  logic       jmp, jmp_nz, dont_jmp, r_wr_en, src_is_imm;
  logic       alu_xsel, alu_ysel;
  logic [3:0] jmp_addr, imm;
  logic [7:0] reg_wr_en;
  logic [2:0] src_sel, alu_func;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_ir   = 8'h80;
  int m_flag = 0;
  int phase  = 0;

  always #5 clk = ~clk;

  instruction_decoder dut (
    .clk(clk), .reset_n(reset_n), .pm_data(pm_data), .run(run),
    .pc_count(pc_count), .alu_zero(alu_zero), .ir(ir), .jmp(jmp),
    .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
    .reg_wr_en(reg_wr_en), .r_wr_en(r_wr_en), .src_sel(src_sel),
    .src_is_imm(src_is_imm), .imm(imm), .alu_xsel(alu_xsel),
    .alu_ysel(alu_ysel), .alu_func(alu_func)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t phase=%0d ir_model=0x%0h)",
               tag, obs, exp, $time, phase, m_ir);
    end
  endtask

  // Expected outputs derived from the instruction-format table by value ranges
  task automatic check_all();
    bit   p3;
    int   dst, src;
    int   e_reg, e_r, e_j, e_nz;
    p3    = (phase == 3);
    e_reg = 0; e_r = 0; e_j = 0; e_nz = 0;
    dst   = (m_ir / 8) % 8;
    src   = m_ir % 8;
    if (m_ir < 128) begin
      if (p3) e_reg = 1 << (m_ir / 16);
    end else if (m_ir < 192) begin
      if (p3 && (dst != src || dst == 4)) e_reg = 1 << dst;
      check_eq("src_sel", src_sel, src);
    end else if (m_ir < 224) begin
      e_r = p3;
    end else if (m_ir < 240) begin
      e_j = p3;
    end else begin
      e_nz = p3;
    end
    check_eq("ir",         ir,         m_ir);
    check_eq("dont_jmp",   dont_jmp,   m_flag);
    check_eq("reg_wr_en",  reg_wr_en,  e_reg);
    check_eq("r_wr_en",    r_wr_en,    e_r);
    check_eq("jmp",        jmp,        e_j);
    check_eq("jmp_nz",     jmp_nz,     e_nz);
    check_eq("nz_taken",   jmp_nz & ~dont_jmp, (e_nz != 0 && m_flag == 0) ? 1 : 0);
    check_eq("jmp_addr",   jmp_addr,   m_ir % 16);
    check_eq("imm",        imm,        m_ir % 16);
    check_eq("src_is_imm", src_is_imm, (m_ir < 128) ? 1 : 0);
    check_eq("alu_xsel",   alu_xsel,   (m_ir / 16) % 2);
    check_eq("alu_ysel",   alu_ysel,   (m_ir / 8) % 2);
    check_eq("alu_func",   alu_func,   m_ir % 8);
  endtask

  // One clock: present inputs for the current phase, take the edge, advance
  // the model, then present the next phase and check.
  task automatic cycle(input logic [7:0] pm, input logic az, input bit extra_run);
    bit cap;
    pm_data  = pm;
    alu_zero = az;
    pc_count = 2'(phase);
    cap      = (phase == 2) || extra_run;
    run      = cap;
    @(posedge clk);
    if (reset_n) begin
      if (phase == 3 && m_ir >= 192 && m_ir < 224) m_flag = az;
      if (cap) m_ir = pm;
    end
    #1;
    phase    = (phase + 1) % 4;
    pc_count = 2'(phase);
    run      = (phase == 2);
    #1;
    check_all();
  endtask

  task automatic slot(input logic [7:0] pm, input logic az);
    for (int k = 0; k < 4; k++) cycle(pm, az, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r_pm;
    logic       r_az;
    reset_n  = 1'b1;
    pm_data  = 8'h00;
    run      = 1'b0;
    pc_count = 2'd0;
    alu_zero = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check_all();
    for (int k = 0; k < 4; k++) cycle(8'h35, 1'b0, 1'b0);
    reset_n = 1'b1;

    // directed program
    slot(8'h35, 1'b0);  // load y1,5
    slot(8'hA4, 1'b0);  // mov o_reg,r
    slot(8'h89, 1'b0);  // mov x1,x1 -> NOP
    slot(8'hC9, 1'b1);  // ALU, zero -> flag 1
    slot(8'hC9, 1'b0);  // ALU, nonzero -> flag 0
    slot(8'hE7, 1'b0);  // jmp 7
    slot(8'hC9, 1'b1);  // flag 1
    slot(8'h35, 1'b0);  // flag holds across load
    slot(8'hA4, 1'b0);  // and mov
    slot(8'hF3, 1'b0);  // jnz 3 with flag set

    // asynchronous reset landing mid phase 2
    cycle(8'h35, 1'b0, 1'b0);
    cycle(8'h35, 1'b0, 1'b0);
    pm_data = 8'h35;
    #2 reset_n = 1'b0;
    #1;
    m_ir = 8'h80;
    m_flag = 0;
    check_all();
    cycle(8'h35, 1'b0, 1'b0);
    cycle(8'h35, 1'b0, 1'b0);
    reset_n = 1'b1;
    slot(8'h12, 1'b0);

    // random program, occasional stray run outside phase 2
    for (int s = 0; s < 200; s++) begin
      r_pm = 8'($urandom);
      r_az = 1'($urandom);
      for (int k = 0; k < 4; k++)
        cycle(r_pm, r_az, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instruction_decoder
`default_nettype wire

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Downstream neighbour of program_sequencer in the 4-bit lab microprocessor.
- Captures the 8-bit word from program memory once per 4-phase instruction cycle, on the sequencer's run phase.
- Decodes it into register-write strobes, source/ALU selects and jump requests.
- Holds the zero flag that produces dont_jmp; jmp, jmp_nz, jmp_addr and dont_jmp feed straight back into program_sequencer.

Parameters:
- IR_RESET, 8'h80, value loaded into the instruction register on reset; decodes as NOP (mov x0,x0).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pm_data  in  8  program-memory output word.
- run  in  1  from sequencer; high only in phase pc_count==2.
- pc_count  in  2  sequencer phase counter, 0..3.
- alu_zero  in  1  ALU result-is-zero, valid in phase 3.
- ir  out  8  instruction register.
- jmp  out  1  unconditional jump request.
- jmp_nz  out  1  jump-if-not-zero request.
- jmp_addr  out  4  jump target nibble (ir[3:0]).
- dont_jmp  out  1  registered zero flag.
- reg_wr_en  out  8  one-hot destination write strobe; bit 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm.
- r_wr_en  out  1  ALU result-register write strobe.
- src_sel  out  3  mov source; 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 i_pins.
- src_is_imm  out  1  load instruction; data comes from imm.
- imm  out  4  immediate (ir[3:0]).
- alu_xsel  out  1  ALU x operand select (ir[4]).
- alu_ysel  out  1  ALU y operand select (ir[3]).
- alu_func  out  3  ALU function (ir[2:0]).

Behaviour:
- Reset, asynchronous, reset_n low:
  - ir=IR_RESET, dont_jmp=0.
  - All strobes and jump requests 0.
  - Reset may land in any phase. After release, the first capture happens at the next run phase.
- Capture:
  - At the rising edge where run==1, ir <= pm_data.
  - At every other edge ir holds.
  - Decode therefore applies during the following phase-3 cycle: one-cycle latency from capture.
- Instruction formats:
  - 0ddd nnnn: load. reg_wr_en[ddd] pulses; src_is_imm=1.
  - 10dd dsss: mov, dst=ir[5:3], src=ir[2:0]. reg_wr_en[dst] pulses; src_sel=sss.
    - NOP when dst==src, except dst=src=4 (o_reg<-r), which is a legal move.
  - 110x yfff: ALU. r_wr_en pulses.
  - 1110 aaaa: jmp.
  - 1111 aaaa: jnz.
- Strobe timing:
  - reg_wr_en, r_wr_en, jmp and jmp_nz are high only while pc_count==3, i.e. exactly one cycle per instruction.
  - They are 0 in phases 0-2.
  - Selects (src_sel, imm, alu_*, jmp_addr) are decoded continuously from ir and are stable all cycle.
- jnz semantics: jmp_nz is raised regardless of the flag; the sequencer combines it with dont_jmp.
- Zero flag:
  - At the edge ending phase 3 of an ALU instruction, dont_jmp <= alu_zero.
  - Every other instruction holds dont_jmp.
- Simultaneous events: reset_n low overrides capture and flag update in the same cycle.
- Illegal phase sequences (run high outside phase 2) still capture. Strobes remain gated by pc_count==3 only.

Decomposition:
- Shared package, e.g. cpu_pkg:
  - opcode prefix constants (LOAD, MOV, ALU, JMP, JNZ);
  - destination and source encodings;
  - ALU function codes;
  - IR_RESET/NOP constant.
- No sub-module needed: one IR/flag register process plus one combinational decode.

Test Plan:
- Reset: assert reset_n=0 mid-phase 2 with pm_data=8'h35 -> ir=8'h80, dont_jmp=0, all strobes 0; no capture until the next run.
- Load: pm_data=8'h35 at run -> next cycle (phase 3) reg_wr_en=8'b0000_1000, src_is_imm=1, imm=5; 0 in the following phases.
- Mov: 8'hA4 (o_reg<-r) -> phase 3 reg_wr_en[4]=1, src_sel=4. Then 8'h89 (x1<-x1) -> reg_wr_en=0 (NOP).
- ALU + flag: 8'hC9 with alu_zero=1 in phase 3 -> r_wr_en pulse, alu_ysel=1, alu_func=1, dont_jmp=1 afterwards. Repeat with alu_zero=0 -> dont_jmp=0.
- Jumps: 8'hE7 -> phase 3 jmp=1, jmp_addr=7. Then 8'hF3 with dont_jmp=1 -> jmp_nz=1, jmp_addr=3, and the sequencer must not branch.
- Flag hold: ALU sets dont_jmp=1, then a load and a mov execute -> dont_jmp stays 1.
